ysyx_22050854_mdu: RTL

Iterative multiply/divide unit executing the RV64M instruction group on the two 64-bit operands produced by the operand source generator. It sits beside the single-cycle ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake, iterates one bit per cycle, and holds the 64-bit result until writeback takes it. A flush input discards in-flight work on redirect.

---
 rtl/ysyx_22050854_mdu_pkg.sv | 25 ++
 rtl/ysyx_22050854_div_core.sv | 41 ++++
 rtl/ysyx_22050854_mdu.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ysyx_22050854_mdu_pkg.sv
// Shared RV64M op codes, MDU state encoding and iteration counts.
package ysyx_22050854_mdu_pkg;
  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  localparam logic [6:0] ITER_D = 7'd64;
  localparam logic [6:0] ITER_W = 7'd32;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

// File: rtl/ysyx_22050854_div_core.sv
// Restoring divider datapath: one quotient bit per step; next-step values are
// exposed so the caller can capture the final result on the last step.
module ysyx_22050854_div_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_w,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic [63:0] quo_nxt,
  output logic [63:0] rem_nxt
);
  logic [63:0] rem, quo, dsr;
  logic [64:0] shifted;
  logic        ge;

  always_comb begin
    shifted = {rem, quo[63]};
    ge      = shifted >= {1'b0, dsr};
    // true difference is below the divisor, so 64-bit wraparound is exact
    rem_nxt = ge ? (shifted[63:0] - dsr) : shifted[63:0];
    quo_nxt = {quo[62:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      dsr <= '0;
    end else if (load) begin
      rem <= '0;
      // W dividends sit in the top half so 32 shifts consume exactly them
      quo <= is_w ? {dividend[31:0], 32'b0} : dividend;
      dsr <= divisor;
    end else if (step) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end
endmodule

// File: rtl/ysyx_22050854_mdu.sv
// Iterative RV64M multiply/divide unit: 65/33 edges to out_valid (1 for special cases),
// one op in flight; result held in DONE until out_ready, flush aborts to IDLE.
module ysyx_22050854_mdu
  import ysyx_22050854_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result
);
  state_t       state;
  logic [6:0]   cnt;
  logic [3:0]   op_q;
  logic         sa_q, sb_q;
  logic [127:0] prod;
  logic [63:0]  mcand;

  logic        is_w, is_div, is_rem, a_sgn, b_sgn, w_sext;
  logic [63:0] a_ext, b_ext, ua, ub, dvd_sx, spec_res;
  logic        sa, sb, div0, ovf, rsvd, special;

  always_comb begin
    is_w   = op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    is_rem = op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    a_sgn  = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    b_sgn  = op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    w_sext = op inside {OP_DIVW, OP_REMW};
    a_ext  = is_w ? (w_sext ? sext32(src1[31:0]) : {32'b0, src1[31:0]}) : src1;
    b_ext  = is_w ? (w_sext ? sext32(src2[31:0]) : {32'b0, src2[31:0]}) : src2;
    sa     = a_sgn & a_ext[63];
    sb     = b_sgn & b_ext[63];
    ua     = sa ? -a_ext : a_ext;
    ub     = sb ? -b_ext : b_ext;
    dvd_sx = is_w ? sext32(src1[31:0]) : src1;
    rsvd   = op > OP_REMUW;
    div0   = is_div && (b_ext == 64'd0);
    ovf    = ((op == OP_DIV || op == OP_REM) && src1 == {1'b1, 63'b0} && (&src2)) ||
             ((op == OP_DIVW || op == OP_REMW) && src1[31:0] == 32'h8000_0000 && (&src2[31:0]));
    special = rsvd | div0 | ovf;
    if (rsvd)      spec_res = '0;
    else if (div0) spec_res = is_rem ? dvd_sx : '1;
    else           spec_res = is_rem ? '0 : dvd_sx;
  end

  logic [64:0]  sum;
  logic [127:0] prod_nxt, pfix;
  logic [63:0]  quo_nxt, rem_nxt, qfix, rfix, calc_res;

  always_comb begin
    sum      = {1'b0, prod[127:64]} + (prod[0] ? {1'b0, mcand} : 65'd0);
    prod_nxt = {sum, prod[63:1]};
    pfix     = (sa_q ^ sb_q) ? -prod_nxt : prod_nxt;
    qfix     = (sa_q ^ sb_q) ? -quo_nxt : quo_nxt;
    rfix     = sa_q ? -rem_nxt : rem_nxt;
    case (op_q)
      OP_MUL:                       calc_res = pfix[63:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = pfix[127:64];
      OP_MULW:                      calc_res = sext32(pfix[63:32]);
      OP_DIV, OP_DIVU:              calc_res = qfix;
      OP_REM, OP_REMU:              calc_res = rfix;
      OP_DIVW, OP_DIVUW:            calc_res = sext32(qfix[31:0]);
      OP_REMW, OP_REMUW:            calc_res = sext32(rfix[31:0]);
      default:                      calc_res = '0;
    endcase
  end

  assign in_ready = (state == ST_IDLE);

  ysyx_22050854_div_core u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (in_ready && in_valid && !flush),
    .step     (state == ST_CALC && !flush),
    .is_w     (is_w),
    .dividend (ua),
    .divisor  (ub),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_q  <= op;
          sa_q  <= sa;
          sb_q  <= sb;
          prod  <= {64'b0, ub};
          mcand <= ua;
          if (special) begin
            result    <= spec_res;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt   <= is_w ? ITER_W : ITER_D;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          prod <= prod_nxt;
          cnt  <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            result    <= calc_res;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
